cmd_router: RTL and testbench

CMD_ROUTER -- requirements
Module: cmd_router

---
 rtl/cmd_router.sv | 132 +++++++++++++
 tb/tb_cmd_router.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_router.sv
// cmd_router: splits an upstream byte stream of header+payload packets to targets
// and merges target response packets downstream with round-robin arbitration.
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/data/next   upstream byte stream; cmd_next pops the current byte
//   tgt_cmd_valid/next    per-target command handshake; tgt_cmd_data is shared
//   tgt_rsp_valid/data/last/ready  per-target response streams (data packed 8 bits each)
//   rsp_ready/valid/data  downstream response byte stream
//   err_count             saturating count of dropped command packets
module cmd_router #(
    parameter int Targets = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [7:0]           cmd_data,
    output logic                 cmd_next,
    output logic [Targets-1:0]   tgt_cmd_valid,
    output logic [7:0]           tgt_cmd_data,
    input  logic [Targets-1:0]   tgt_cmd_next,
    input  logic [Targets-1:0]   tgt_rsp_valid,
    input  logic [8*Targets-1:0] tgt_rsp_data,
    input  logic [Targets-1:0]   tgt_rsp_last,
    output logic [Targets-1:0]   tgt_rsp_ready,
    input  logic                 rsp_ready,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_data,
    output logic [7:0]           err_count
);
    typedef enum logic [1:0] {HDR, PAY, DROP} cmd_state_e;
    typedef enum logic {IDLE, LOCK} arb_state_e;

    cmd_state_e cmd_state_q;
    arb_state_e arb_state_q;
    logic [1:0] tgt_q;
    logic [5:0] rem_q;
    logic [7:0] err_q;
    logic [1:0] grant_q;
    logic [1:0] last_grant_q;
    logic       sel_next;
    logic       grant_valid;
    logic       grant_last;
    logic [7:0] grant_data;
    logic       pick_valid;
    logic [1:0] pick;

    assign tgt_cmd_data = cmd_data;
    assign err_count    = err_q;

    // Select the signals of the addressed target and of the granted target.
    always_comb begin
        sel_next    = 1'b0;
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        grant_data  = 8'h00;
        for (int i = 0; i < Targets; i++) begin
            if (tgt_q == 2'(i)) sel_next = tgt_cmd_next[i];
            if (grant_q == 2'(i)) begin
                grant_valid = tgt_rsp_valid[i];
                grant_last  = tgt_rsp_last[i];
                grant_data  = tgt_rsp_data[8*i +: 8];
            end
        end
    end

    // Round-robin search: descending k so the nearest candidate after last_grant wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = 2'd0;
        for (int k = Targets; k >= 1; k--) begin
            for (int j = 0; j < Targets; j++) begin
                if (tgt_rsp_valid[j] && j == (int'(last_grant_q) + k) % Targets) begin
                    pick_valid = 1'b1;
                    pick       = 2'(j);
                end
            end
        end
    end

    // Handshake outputs are all held low during reset.
    always_comb begin
        cmd_next      = 1'b0;
        tgt_cmd_valid = '0;
        tgt_rsp_ready = '0;
        rsp_valid     = !reset && arb_state_q == LOCK && grant_valid && rsp_ready;
        rsp_data      = grant_data;
        if (!reset) begin
            cmd_next = (cmd_state_q == PAY) ? cmd_valid & sel_next : cmd_valid;
            for (int i = 0; i < Targets; i++) begin
                if (cmd_state_q == PAY && tgt_q == 2'(i)) tgt_cmd_valid[i] = cmd_valid;
                if (arb_state_q == LOCK && grant_q == 2'(i)) tgt_rsp_ready[i] = rsp_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_state_q <= HDR;
            tgt_q       <= 2'd0;
            rem_q       <= 6'd0;
            err_q       <= 8'd0;
        end else if (cmd_state_q == HDR) begin
            if (cmd_valid) begin
                tgt_q       <= cmd_data[7:6];
                rem_q       <= cmd_data[5:0];
                cmd_state_q <= (int'(cmd_data[7:6]) < Targets) ? PAY : DROP;
            end
        end else if (cmd_next) begin
            if (rem_q == 6'd0) begin
                cmd_state_q <= HDR;
                if (cmd_state_q == DROP && err_q != 8'hFF) err_q <= err_q + 8'd1;
            end else begin
                rem_q <= rem_q - 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_state_q  <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'(Targets - 1);
        end else if (arb_state_q == IDLE) begin
            if (pick_valid) begin
                grant_q     <= pick;
                arb_state_q <= LOCK;
            end
        end else if (rsp_valid && grant_last) begin
            last_grant_q <= grant_q;
            arb_state_q  <= IDLE;
        end
    end
endmodule

// File: tb/tb_cmd_router.sv
// tb_cmd_router: directed and randomized checks of cmd_router (Targets=2)
// against a packet-level reference model.
module tb_cmd_router;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_next;
    logic [1:0]  tgt_cmd_valid;
    logic [7:0]  tgt_cmd_data;
    logic [1:0]  tgt_cmd_next = 2'b00;
    logic [1:0]  tgt_rsp_valid = 2'b00;
    logic [15:0] tgt_rsp_data = 16'h0000;
    logic [1:0]  tgt_rsp_last = 2'b00;
    logic [1:0]  tgt_rsp_ready;
    logic        rsp_ready = 1'b0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    logic [8:0] rq[2][$];
    logic [7:0] got[2][$];
    logic [7:0] cexp[2][$];
    logic [7:0] rexp[2][$];
    int         plen[2][$];
    logic [7:0] oq[$];
    int         ocyc[$];
    logic [7:0] cq[$];
    logic [7:0] eq[$];

    cmd_router #(.Targets(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_next(cmd_next),
        .tgt_cmd_valid(tgt_cmd_valid), .tgt_cmd_data(tgt_cmd_data), .tgt_cmd_next(tgt_cmd_next),
        .tgt_rsp_valid(tgt_rsp_valid), .tgt_rsp_data(tgt_rsp_data), .tgt_rsp_last(tgt_rsp_last),
        .tgt_rsp_ready(tgt_rsp_ready), .rsp_ready(rsp_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive target responses from rq, observe, then advance.
    task automatic step(input logic [1:0] hold, input logic rdy);
        logic [1:0] pop_r;
        logic       pop_c;
        for (int i = 0; i < 2; i++) begin
            tgt_rsp_valid[i]       = rq[i].size() > 0 && !hold[i];
            tgt_rsp_data[8*i +: 8] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
            tgt_rsp_last[i]        = rq[i].size() > 0 ? rq[i][0][8] : 1'b0;
        end
        rsp_ready = rdy;
        #1;
        chk("rsp_valid_needs_ready", rsp_valid & ~rsp_ready, 0);
        chk("rsp_ready_onehot", $countones(tgt_rsp_ready) <= 1, 1);
        chk("tgt_cmd_data_pass", tgt_cmd_data, cmd_data);
        chk("tgt_cmd_valid_gated", $countones(tgt_cmd_valid) <= (cmd_valid ? 1 : 0), 1);
        if (rsp_valid) begin
            oq.push_back(rsp_data);
            ocyc.push_back(cyc_n);
        end
        for (int i = 0; i < 2; i++)
            if (tgt_cmd_valid[i] && tgt_cmd_next[i]) got[i].push_back(tgt_cmd_data);
        pop_r = tgt_rsp_valid & tgt_rsp_ready;
        pop_c = cmd_valid && cmd_next && cq.size() > 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (pop_r[i]) void'(rq[i].pop_front());
        if (pop_c) void'(cq.pop_front());
        cyc_n++;
    endtask

    task automatic cmd_probe(input logic [7:0] b, input logic [1:0] nxt, input logic exp_next,
                             input logic [1:0] exp_tv, input string tag);
        cmd_valid = 1'b1;
        cmd_data = b;
        tgt_cmd_next = nxt;
        #1;
        chk({tag, "_cmd_next"}, cmd_next, exp_next);
        chk({tag, "_tgt_cmd_valid"}, tgt_cmd_valid, exp_tv);
        step(2'b00, 1'b0);
        cmd_valid = 1'b0;
    endtask

    // A header state pops any byte and forwards nothing; the byte is withdrawn before the edge.
    task automatic hdr_probe(input string tag);
        cmd_valid = 1'b1;
        cmd_data = 8'h81;
        tgt_cmd_next = 2'b11;
        #1;
        chk({tag, "_cmd_next"}, cmd_next, 1);
        chk({tag, "_tgt_cmd_valid"}, tgt_cmd_valid, 0);
        cmd_valid = 1'b0;
        step(2'b00, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);
        reset = 1'b0;
    endtask

    task automatic drain(input int budget, input logic toggle, input string tag);
        int n = 0;
        while ((rq[0].size() > 0 || rq[1].size() > 0) && n < budget) begin
            step(2'b00, toggle ? 1'(n % 2) : 1'b1);
            n++;
        end
        chk({tag, "_drained"}, rq[0].size() + rq[1].size(), 0);
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_len"}, oq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < oq.size(); i++) chk({tag, "_byte"}, oq[i], eq[i]);
    endtask

    task automatic chk_got(input int t, input string tag);
        chk({tag, "_len"}, got[t].size(), eq.size());
        for (int i = 0; i < eq.size() && i < got[t].size(); i++) chk({tag, "_byte"}, got[t][i], eq[i]);
    endtask

    initial begin
        int drops, n, rem, cur, t, len;
        logic [7:0] b;
        logic [6:0] seq;
        @(posedge clk);
        #1;
        // Reset holds every handshake output low even with all inputs active.
        cmd_valid = 1'b1; cmd_data = 8'h42; tgt_cmd_next = 2'b11; rsp_ready = 1'b1;
        tgt_rsp_valid = 2'b11; tgt_rsp_last = 2'b11;
        rq[0].push_back(9'h101);
        rq[1].push_back(9'h102);
        repeat (2) begin
            #1;
            chk("reset_cmd_next", cmd_next, 0);
            chk("reset_tgt_cmd_valid", tgt_cmd_valid, 0);
            chk("reset_tgt_rsp_ready", tgt_rsp_ready, 0);
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_err_count", err_count, 0);
            step(2'b00, 1'b1);
        end
        reset = 1'b0; cmd_valid = 1'b0;
        rq[0].delete(); rq[1].delete();

        // Header 0x42: three bytes to target 1; a foreign next bit is ignored.
        got[0].delete(); got[1].delete();
        cmd_probe(8'h42, 2'b10, 1'b1, 2'b00, "hdr42");
        cmd_probe(8'hAA, 2'b01, 1'b0, 2'b10, "pay_foreign_next");
        cmd_probe(8'hAA, 2'b10, 1'b1, 2'b10, "pay_aa");
        cmd_probe(8'hBB, 2'b10, 1'b1, 2'b10, "pay_bb");
        cmd_probe(8'hCC, 2'b10, 1'b1, 2'b10, "pay_cc");
        hdr_probe("after_42");
        eq = '{8'hAA, 8'hBB, 8'hCC};
        chk_got(1, "t1_payload");
        chk("t0_untouched", got[0].size(), 0);

        // Reset mid-packet: the next byte is a header.
        do_reset();
        cmd_probe(8'h03, 2'b01, 1'b1, 2'b00, "hdr03");
        cmd_probe(8'h11, 2'b01, 1'b1, 2'b01, "pay11");
        do_reset();
        got[0].delete(); got[1].delete();
        cmd_probe(8'h00, 2'b01, 1'b1, 2'b00, "hdr00_after_reset");
        cmd_probe(8'h77, 2'b01, 1'b1, 2'b01, "pay77");
        hdr_probe("after_77");
        eq = '{8'h77};
        chk_got(0, "t0_after_reset");
        chk("t1_after_reset", got[1].size(), 0);
        chk("err_before_drop", err_count, 0);

        // Dropped packets to target 3 count and saturate.
        cmd_probe(8'hC0, 2'b00, 1'b1, 2'b00, "hdrC0");
        cmd_probe(8'h55, 2'b00, 1'b1, 2'b00, "drop55");
        chk("err_one_drop", err_count, 1);
        for (int p = 1; p <= 255; p++) begin
            cmd_valid = 1'b1; cmd_data = 8'hC0;
            step(2'b00, 1'b0);
            cmd_data = 8'h55;
            step(2'b00, 1'b0);
            cmd_valid = 1'b0;
            if (p == 253) chk("err_254", err_count, 254);
            if (p == 254) chk("err_255", err_count, 255);
        end
        chk("err_saturated", err_count, 255);

        // Round robin from reset: T0, T1, then T0 again, one idle cycle between packets.
        do_reset();
        oq.delete(); ocyc.delete(); cyc_n = 0;
        rq[0] = '{9'h0A1, 9'h1A2, 9'h0A3, 9'h1A4};
        rq[1] = '{9'h0B1, 9'h1B2};
        drain(40, 1'b0, "rr");
        eq = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hA3, 8'hA4};
        chk_out("rr");
        chk("rr_gap", ocyc.size() >= 3 ? ocyc[2] - ocyc[1] : -1, 2);
        chk("rr_first_latency", ocyc.size() > 0 && ocyc[0] >= 1, 1);

        // T1 stalls mid-packet while T0 is valid: grant stays on T1.
        oq.delete();
        rq[1] = '{9'h0B5, 9'h0B6, 9'h1B7};
        rq[0] = '{9'h0A5, 9'h1A6};
        step(2'b01, 1'b1);
        step(2'b01, 1'b1);
        repeat (3) step(2'b10, 1'b1);
        chk("stall_held", oq.size(), 1);
        drain(40, 1'b0, "stall");
        eq = '{8'hB5, 8'hB6, 8'hB7, 8'hA5, 8'hA6};
        chk_out("stall");

        // rsp_ready toggling every cycle during a 3-byte packet.
        oq.delete();
        rq[0] = '{9'h0C1, 9'h0C2, 9'h1C3};
        drain(40, 1'b1, "toggle");
        eq = '{8'hC1, 8'hC2, 8'hC3};
        chk_out("toggle");

        // Randomized concurrent traffic checked against packet-level expectations.
        do_reset();
        got[0].delete(); got[1].delete(); oq.delete(); cq.delete();
        drops = 0;
        for (int p = 0; p < 25; p++) begin
            t = int'($urandom % 4);
            len = ($urandom % 8 == 0) ? 64 : 1 + int'($urandom % 5);
            cq.push_back({2'(t), 6'(len - 1)});
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom);
                cq.push_back(b);
                if (t < 2) cexp[t].push_back(b);
            end
            if (t >= 2) drops++;
        end
        for (int i = 0; i < 2; i++) begin
            seq = 7'd0;
            for (int p = 0; p < 6; p++) begin
                len = 1 + int'($urandom % 4);
                plen[i].push_back(len);
                for (int k = 0; k < len; k++) begin
                    rq[i].push_back({1'(k == len - 1), 1'(i), seq});
                    rexp[i].push_back({1'(i), seq});
                    seq++;
                end
            end
        end
        n = 0;
        while ((cq.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0) && n < 5000) begin
            cmd_valid = cq.size() > 0 && ($urandom % 4 != 0);
            cmd_data = cmd_valid ? cq[0] : 8'($urandom);
            tgt_cmd_next = 2'($urandom);
            step(2'($urandom) & 2'($urandom), $urandom % 4 != 0);
            n++;
        end
        cmd_valid = 1'b0;
        chk("rand_all_consumed", cq.size() + rq[0].size() + rq[1].size(), 0);
        chk("rand_err_count", err_count, drops);
        for (int i = 0; i < 2; i++) begin
            eq = cexp[i];
            chk_got(i, "rand_cmd");
        end
        rem = 0;
        cur = 0;
        for (int i = 0; i < oq.size(); i++) begin
            t = int'(oq[i][7]);
            if (rem == 0) begin
                cur = t;
                rem = plen[t].size() > 0 ? plen[t].pop_front() : 1;
            end else begin
                chk("rand_no_interleave", t, cur);
            end
            chk("rand_rsp_byte", oq[i], rexp[t].size() > 0 ? {24'h0, rexp[t].pop_front()} : 32'hFFFF);
            rem--;
        end
        chk("rand_rsp_complete", rexp[0].size() + rexp[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
